// File: rtl/hazard_ctrl.sv
// Hazard controller for a short in-order pipeline.
//
// Stalls fetch and execute/writeback while a data-memory access is outstanding, aborts the
// access after TIMEOUT wait cycles (flushing execute/writeback and raising a sticky error),
// flushes fetch on a taken branch once the pipeline is unstalled, and selects the writeback
// result as an execute operand when the register numbers match.
//
// Ports:
//   clk        - clock, all state updates on posedge
//   rst        - asynchronous active-low reset
//   raddr1E    - rs1 of the execute-stage instruction
//   raddr2E    - rs2 of the execute-stage instruction
//   waddrW     - destination register of the writeback-stage instruction
//   reg_wrW    - writeback-stage instruction writes the register file
//   mem_reqW   - writeback-stage instruction is a load or store
//   mem_ready  - data memory completes the current access this cycle
//   br_takenE  - branch/jump resolved taken in execute
//   StallF     - hold the fetch pipeline register
//   StallE     - hold the execute/writeback pipeline register
//   FlushF     - zero the fetch pipeline register on the next edge
//   FlushE     - zero the execute/writeback pipeline register on the next edge
//   ForwardAE  - use the writeback result for operand A
//   ForwardBE  - use the writeback result for operand B
//   mem_err    - sticky: a memory access timed out
module hazard_ctrl #(
  parameter int unsigned TIMEOUT = 16
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [4:0] raddr1E,
  input  logic [4:0] raddr2E,
  input  logic [4:0] waddrW,
  input  logic       reg_wrW,
  input  logic       mem_reqW,
  input  logic       mem_ready,
  input  logic       br_takenE,
  output logic       StallF,
  output logic       StallE,
  output logic       FlushF,
  output logic       FlushE,
  output logic       ForwardAE,
  output logic       ForwardBE,
  output logic       mem_err
);

  typedef enum logic [1:0] {StIdle, StWait, StAbort} state_e;

  // The first stalled cycle is spent in StIdle and counts as wait cycle 1, so the access is
  // abandoned from StWait once the counter would step onto TIMEOUT.
  localparam logic [7:0] TimeoutLast = 8'(TIMEOUT - 1);

  state_e     state_q, state_d;
  logic [7:0] cnt_q, cnt_d;
  logic       mem_err_q, mem_err_d;
  logic       stall;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      StIdle: begin
        if (mem_reqW && !mem_ready) begin
          state_d = StWait;
          cnt_d   = 8'd1;
        end
      end
      StWait: begin
        if (mem_ready) begin
          state_d = StIdle;
          cnt_d   = 8'd0;
        end else if (cnt_q >= TimeoutLast) begin
          state_d = StAbort;
          cnt_d   = cnt_q + 8'd1;
        end else begin
          cnt_d   = cnt_q + 8'd1;
        end
      end
      StAbort: begin
        state_d = StIdle;
        cnt_d   = 8'd0;
      end
      default: begin
        state_d = StIdle;
        cnt_d   = 8'd0;
      end
    endcase
  end

  // Error is raised on the same edge that enters StAbort and is only cleared by reset.
  assign mem_err_d = mem_err_q | (state_d == StAbort);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q   <= StIdle;
      cnt_q     <= 8'd0;
      mem_err_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      mem_err_q <= mem_err_d;
    end
  end

  // All decision outputs are gated by rst so they drop the moment reset asserts, even while
  // mem_reqW/br_takenE are still driven.
  always_comb begin
    stall = rst && (((state_q == StIdle) && mem_reqW && !mem_ready) ||
                    ((state_q == StWait) && !mem_ready));
    StallF    = stall;
    StallE    = stall;
    // A branch held in execute during a stall flushes fetch in the first unstalled cycle.
    FlushF    = rst && br_takenE && !stall;
    FlushE    = rst && (state_q == StAbort);
    ForwardAE = rst && reg_wrW && (waddrW != 5'd0) && (waddrW == raddr1E) &&
                (state_q != StAbort);
    ForwardBE = rst && reg_wrW && (waddrW != 5'd0) && (waddrW == raddr2E) &&
                (state_q != StAbort);
    mem_err   = mem_err_q;
  end

endmodule

// File: tb/tb_hazard_ctrl.sv
module tb_hazard_ctrl;

  logic       clk = 1'b0;
  logic       rst;
  logic [4:0] raddr1E, raddr2E, waddrW;
  logic       reg_wrW, mem_reqW, mem_ready, br_takenE;
  logic       StallF, StallE, FlushF, FlushE, ForwardAE, ForwardBE, mem_err;

  // Observed vector: {StallF, StallE, FlushF, FlushE, ForwardAE, ForwardBE, mem_err}
  logic [6:0] obs;
  assign obs = {StallF, StallE, FlushF, FlushE, ForwardAE, ForwardBE, mem_err};

  logic [6:0] sb[$];
  int n_checks = 0;
  int n_fail   = 0;

  hazard_ctrl #(.TIMEOUT(16)) dut (
    .clk       (clk),
    .rst       (rst),
    .raddr1E   (raddr1E),
    .raddr2E   (raddr2E),
    .waddrW    (waddrW),
    .reg_wrW   (reg_wrW),
    .mem_reqW  (mem_reqW),
    .mem_ready (mem_ready),
    .br_takenE (br_takenE),
    .StallF    (StallF),
    .StallE    (StallE),
    .FlushF    (FlushF),
    .FlushE    (FlushE),
    .ForwardAE (ForwardAE),
    .ForwardBE (ForwardBE),
    .mem_err   (mem_err)
  );

  always #5 clk = ~clk;

  // Inputs change on the falling edge; outputs are sampled 1 time unit later.
  task automatic drive(input logic req, input logic rdy, input logic br, input logic wr,
                       input logic [4:0] wa, input logic [4:0] r1, input logic [4:0] r2);
    @(negedge clk);
    mem_reqW  = req;
    mem_ready = rdy;
    br_takenE = br;
    reg_wrW   = wr;
    waddrW    = wa;
    raddr1E   = r1;
    raddr2E   = r2;
  endtask

  task automatic test_reset();
    logic [6:0] e;
    rst = 1'b0;
    for (int i = 0; i < 2; i++) begin
      drive(1'b1, 1'b0, 1'b1, 1'b1, 5'd5, 5'd5, 5'd5);
      sb.push_back(7'b0000000);
      #1;
      e = sb.pop_front();
      n_checks++;
      if (obs !== e) begin
        n_fail++;
        $display("FAIL reset_hold cyc%0d: got %b expected %b", i, obs, e);
      end
    end
    drive(1'b0, 1'b0, 1'b0, 1'b0, 5'd0, 5'd0, 5'd0);
    rst = 1'b1;
    sb.push_back(7'b0000000);
    #1;
    e = sb.pop_front();
    n_checks++;
    if (obs !== e) begin
      n_fail++;
      $display("FAIL reset_release: got %b expected %b", obs, e);
    end
  endtask

  task automatic test_load_wait();
    logic [6:0] e;
    for (int i = 1; i <= 5; i++) begin
      drive(i <= 4, i == 4, 1'b0, 1'b0, 5'd0, 5'd0, 5'd0);
      sb.push_back(i <= 3 ? 7'b1100000 : 7'b0000000);
      #1;
      e = sb.pop_front();
      n_checks++;
      if (obs !== e) begin
        n_fail++;
        $display("FAIL load_wait cyc%0d: got %b expected %b", i, obs, e);
      end
    end
  endtask

  task automatic test_zero_stall();
    logic [6:0] e;
    for (int i = 0; i < 3; i++) begin
      drive(1'b1, 1'b1, 1'b0, 1'b0, 5'd0, 5'd0, 5'd0);
      sb.push_back(7'b0000000);
      #1;
      e = sb.pop_front();
      n_checks++;
      if (obs !== e) begin
        n_fail++;
        $display("FAIL zero_stall cyc%0d: got %b expected %b", i, obs, e);
      end
    end
  endtask

  task automatic test_branch();
    logic [6:0] e;
    // Unstalled branch flushes fetch immediately.
    drive(1'b0, 1'b0, 1'b1, 1'b0, 5'd0, 5'd0, 5'd0);
    sb.push_back(7'b0010000);
    #1;
    e = sb.pop_front();
    n_checks++;
    if (obs !== e) begin
      n_fail++;
      $display("FAIL branch_free: got %b expected %b", obs, e);
    end
    // 4-cycle wait, branch arrives on wait cycle 2 and is held in execute.
    for (int i = 1; i <= 6; i++) begin
      drive(i <= 5, i == 5, (i >= 2) && (i <= 5), 1'b0, 5'd0, 5'd0, 5'd0);
      if (i <= 4)      sb.push_back(7'b1100000);
      else if (i == 5) sb.push_back(7'b0010000);
      else             sb.push_back(7'b0000000);
      #1;
      e = sb.pop_front();
      n_checks++;
      if (obs !== e) begin
        n_fail++;
        $display("FAIL branch_stall cyc%0d: got %b expected %b", i, obs, e);
      end
    end
  endtask

  task automatic test_forward();
    logic [6:0] e;
    logic [4:0] wa[6] = '{5'd5, 5'd0, 5'd0, 5'd5, 5'd31, 5'd12};
    logic [4:0] r1[6] = '{5'd5, 5'd5, 5'd0, 5'd5, 5'd31, 5'd4};
    logic [4:0] r2[6] = '{5'd5, 5'd5, 5'd0, 5'd5, 5'd3,  5'd12};
    logic       wr[6] = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b1,  1'b1};
    logic [1:0] ab[6] = '{2'b11, 2'b00, 2'b00, 2'b00, 2'b10, 2'b01};
    for (int i = 0; i < 6; i++) begin
      drive(1'b0, 1'b0, 1'b0, wr[i], wa[i], r1[i], r2[i]);
      sb.push_back({4'b0000, ab[i], 1'b0});
      #1;
      e = sb.pop_front();
      n_checks++;
      if (obs !== e) begin
        n_fail++;
        $display("FAIL forward vec%0d: got %b expected %b", i, obs, e);
      end
    end
  endtask

  task automatic test_timeout();
    logic [6:0] e;
    // Forward inputs match rs1 throughout so the ABORT cycle's suppression is visible.
    for (int i = 1; i <= 20; i++) begin
      drive(i <= 19, i == 19, 1'b0, 1'b1, 5'd5, 5'd5, 5'd7);
      if (i <= 16)      sb.push_back(7'b1100100);
      else if (i == 17) sb.push_back(7'b0001001);
      else if (i == 18) sb.push_back(7'b1100101);
      else              sb.push_back(7'b0000101);
      #1;
      e = sb.pop_front();
      n_checks++;
      if (obs !== e) begin
        n_fail++;
        $display("FAIL timeout cyc%0d: got %b expected %b", i, obs, e);
      end
    end
  endtask

  task automatic test_reset_mid_wait();
    logic [6:0] e;
    // Seven stalled cycles leave the wait counter at 7; mem_err still set from the timeout.
    for (int i = 1; i <= 7; i++) begin
      drive(1'b1, 1'b0, 1'b0, 1'b0, 5'd0, 5'd0, 5'd0);
      sb.push_back(7'b1100001);
      #1;
      e = sb.pop_front();
      n_checks++;
      if (obs !== e) begin
        n_fail++;
        $display("FAIL mid_wait cyc%0d: got %b expected %b", i, obs, e);
      end
    end
    for (int i = 0; i < 2; i++) begin
      drive(1'b1, 1'b0, 1'b1, 1'b1, 5'd5, 5'd5, 5'd5);
      rst = 1'b0;
      sb.push_back(7'b0000000);
      #1;
      e = sb.pop_front();
      n_checks++;
      if (obs !== e) begin
        n_fail++;
        $display("FAIL async_reset cyc%0d: got %b expected %b", i, obs, e);
      end
    end
    for (int i = 0; i < 4; i++) begin
      drive(i <= 2, (i == 0) || (i == 2), 1'b0, 1'b0, 5'd0, 5'd0, 5'd0);
      rst = 1'b1;
      sb.push_back(i == 1 ? 7'b1100000 : 7'b0000000);
      #1;
      e = sb.pop_front();
      n_checks++;
      if (obs !== e) begin
        n_fail++;
        $display("FAIL post_reset cyc%0d: got %b expected %b", i, obs, e);
      end
    end
  endtask

  initial begin
    rst       = 1'b0;
    mem_reqW  = 1'b0;
    mem_ready = 1'b0;
    br_takenE = 1'b0;
    reg_wrW   = 1'b0;
    waddrW    = 5'd0;
    raddr1E   = 5'd0;
    raddr2E   = 5'd0;
    test_reset();
    test_load_wait();
    test_zero_stall();
    test_branch();
    test_forward();
    test_timeout();
    test_reset_mid_wait();
    if (sb.size() != 0) begin
      n_checks++;
      n_fail++;
      $display("FAIL scoreboard_drain: got %0d entries left expected 0", sb.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/hazard_ctrl.md
HAZARD_CTRL -- requirements
Module: hazard_ctrl

Interface
REQ-001 SHALL have parameter TIMEOUT, default 16, the maximum data-memory wait cycles before abort (legal range 2..255).
REQ-002 SHALL have port clk  input  1  single clock; all state updates on posedge.
REQ-003 SHALL have port rst  input  1  reset; asynchronous, active-low.
REQ-004 SHALL have port raddr1E  input  5  rs1 of the instruction in the decode/execute stage.
REQ-005 SHALL have port raddr2E  input  5  rs2 of the instruction in the decode/execute stage.
REQ-006 SHALL have port waddrW  input  5  destination of the instruction in the memory/writeback stage.
REQ-007 SHALL have port reg_wrW  input  1  memory/writeback instruction writes the register file.
REQ-008 SHALL have port mem_reqW  input  1  memory/writeback instruction is a load or store.
REQ-009 SHALL have port mem_ready  input  1  data memory completes the current access this cycle.
REQ-010 SHALL have port br_takenE  input  1  branch/jump resolved taken in execute.
REQ-011 SHALL have port StallF, StallE  output  1 each  hold the fetch and execute/writeback pipeline registers.
REQ-012 SHALL have port FlushF, FlushE  output  1 each  zero the fetch and execute/writeback pipeline registers on the next edge.
REQ-013 SHALL have port ForwardAE, ForwardBE  output  1 each  select the writeback result for operand A/B.
REQ-014 SHALL have port mem_err  output  1  sticky flag: a memory access timed out.

Function
REQ-015 SHALL implement FSM states IDLE, WAIT, ABORT.
REQ-016 IDLE: mem_reqW=1 and mem_ready=0 -> WAIT, wait counter loaded with 1; otherwise stay IDLE.
REQ-017 IDLE with mem_reqW=1 and mem_ready=1 SHALL produce zero stall cycles.
REQ-018 WAIT: mem_ready=1 -> IDLE; counter reaching TIMEOUT with mem_ready=0 -> ABORT; otherwise counter increments by 1 (8-bit, never wraps).
REQ-019 ABORT SHALL last exactly one cycle, then return to IDLE unconditionally.
REQ-020 StallF=StallE=1 SHALL be asserted combinationally whenever (IDLE and mem_reqW and not mem_ready) or WAIT-and-not-mem_ready; deasserted in the cycle mem_ready rises.
REQ-021 ABORT SHALL assert FlushE=1, StallF=StallE=0, and set mem_err on the same edge that enters ABORT.
REQ-022 mem_err SHALL remain 1 until reset; further timeouts do not alter it.
REQ-023 br_takenE=1 with no stall SHALL assert FlushF=1 in the same cycle.
REQ-024 br_takenE during a stall SHALL NOT assert FlushF; the branch is held in execute, and FlushF asserts in the first unstalled cycle.
REQ-025 Stall SHALL take priority over flush on every register except in ABORT, where FlushE wins.
REQ-026 ForwardAE=1 iff reg_wrW=1, waddrW!=0, waddrW==raddr1E, and the state is not ABORT; ForwardBE likewise on raddr2E.
REQ-027 Forwarding outputs SHALL be purely combinational (zero latency); all other decisions follow REQ-016..025.
REQ-028 x0 SHALL never be forwarded regardless of reg_wrW.

Reset
REQ-029 rst=0 SHALL immediately force state IDLE, counter 0, and mem_err 0, independent of clk.
REQ-030 During reset, all stall, flush, and forward outputs SHALL be 0.
REQ-031 Reset asserted in WAIT SHALL abandon the access; after release the FSM is in IDLE with no stall unless mem_reqW and not mem_ready.

Verification
REQ-032 Load with mem_ready held 0 for 3 cycles then 1 -> StallF/StallE high for exactly 3 cycles, low on the ready cycle, mem_err=0.
REQ-033 mem_reqW=1, mem_ready=0 forever, TIMEOUT=16 -> stall for 16 cycles, then one ABORT cycle with FlushE=1 and stalls 0, mem_err=1 thereafter.
REQ-034 br_takenE=1 on cycle 2 of a 4-cycle wait -> FlushF=0 while stalled, FlushF=1 in the first cycle after mem_ready.
REQ-035 waddrW=5, reg_wrW=1, raddr1E=5, raddr2E=5 -> ForwardAE=ForwardBE=1; waddrW=0 with the same inputs -> both 0.
REQ-036 rst pulled low mid-WAIT (counter=7) -> outputs 0 asynchronously; after release, a new access with immediate mem_ready produces no stall.
